// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    REQ_IFU,
    REQ_LSU
  } req_id_t;

  // Load types understood by the mem block.
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker for the IFU/LSU memory arbiter.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  // A sole requester wins; on conflict the requester not served last time wins.
  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant       = REQ_IFU;
    if (ifu_valid && lsu_valid) begin
      grant = (last_grant == REQ_IFU) ? REQ_LSU : REQ_IFU;
    end else if (lsu_valid) begin
      grant = REQ_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the IFU and the LSU, one access at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  input  logic        ifu_resp_ready,

  input  logic        lsu_req_valid,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  input  logic [2:0]  lsu_req_readop,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  input  logic        lsu_resp_ready,

  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic [2:0]  mem_readop,
  input  logic [31:0] mem_rdata
);

  // WAIT counts down from MEM_LAT-2 so ACCESS lands exactly MEM_LAT cycles after acceptance.
  localparam logic [MEM_LAT_W-1:0] LatLoad =
      (MEM_LAT >= 2) ? MEM_LAT_W'(MEM_LAT - 2) : '0;

  state_t               state_q, state_d;
  req_id_t              last_grant_q, last_grant_d;
  req_id_t              id_q, id_d;
  logic [MEM_LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic                 wen_q, wen_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [7:0]           wmask_q, wmask_d;
  logic [2:0]           readop_q, readop_d;
  logic [31:0]          rdata_q, rdata_d;

  logic grant;
  logic grant_valid;
  logic resp_ready_sel;

  mem_arb_rr u_rr (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign resp_ready_sel = (id_q == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready;

  // State and request/response registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_IFU;
      id_q         <= REQ_IFU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      readop_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      readop_q     <= readop_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic: accept in IDLE, count latency in WAIT, access once, hold response.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    readop_d     = readop_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d         = req_id_t'(grant);
          last_grant_d = req_id_t'(grant);
          if (grant == REQ_LSU) begin
            addr_d   = lsu_req_addr;
            wen_d    = lsu_req_wen;
            wdata_d  = lsu_req_wdata;
            wmask_d  = lsu_req_wmask;
            readop_d = lsu_req_readop;
          end else begin
            // Fetches are always full-word reads.
            addr_d   = ifu_req_addr;
            wen_d    = 1'b0;
            wdata_d  = '0;
            wmask_d  = '0;
            readop_d = OP_LW;
          end
          if (MEM_LAT == 1) begin
            state_d = ACCESS;
          end else begin
            cnt_d   = LatLoad;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - MEM_LAT_W'(1);
        end
      end
      ACCESS: begin
        rdata_d = wen_q ? '0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE to the winner, strobes only in ACCESS, none while in reset.
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    if ((state_q == IDLE) && grant_valid && !rst) begin
      ifu_req_ready = (grant == REQ_IFU);
      lsu_req_ready = (grant == REQ_LSU);
    end
    ifu_resp_valid = (state_q == RESP) && (id_q == REQ_IFU) && !rst;
    lsu_resp_valid = (state_q == RESP) && (id_q == REQ_LSU) && !rst;
    ifu_resp_data  = rdata_q;
    lsu_resp_data  = rdata_q;
    mem_valid      = (state_q == ACCESS) && !wen_q && !rst;
    mem_wen        = (state_q == ACCESS) && wen_q && !rst;
    mem_raddr      = addr_q;
    mem_waddr      = addr_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
    mem_readop     = readop_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (MEM_LAT 1, 3, 5) share stimulus.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_ready;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic [2:0]  lsu_req_readop;
  logic        lsu_resp_ready;
  logic [31:0] mem_rdata;

  logic [2:0]  ifu_req_ready;
  logic [2:0]  ifu_resp_valid;
  logic [31:0] ifu_resp_data [3];
  logic [2:0]  lsu_req_ready;
  logic [2:0]  lsu_resp_valid;
  logic [31:0] lsu_resp_data [3];
  logic [2:0]  mem_valid;
  logic [2:0]  mem_wen;
  logic [31:0] mem_raddr [3];
  logic [31:0] mem_waddr [3];
  logic [31:0] mem_wdata [3];
  logic [7:0]  mem_wmask [3];
  logic [2:0]  mem_readop [3];

  int total;
  int bad;

  mem_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready[0]), .ifu_resp_valid(ifu_resp_valid[0]),
    .ifu_resp_data(ifu_resp_data[0]), .ifu_resp_ready(ifu_resp_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_req_readop(lsu_req_readop), .lsu_req_ready(lsu_req_ready[0]),
    .lsu_resp_valid(lsu_resp_valid[0]), .lsu_resp_data(lsu_resp_data[0]),
    .lsu_resp_ready(lsu_resp_ready),
    .mem_valid(mem_valid[0]), .mem_wen(mem_wen[0]), .mem_raddr(mem_raddr[0]),
    .mem_waddr(mem_waddr[0]), .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]),
    .mem_readop(mem_readop[0]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready[1]), .ifu_resp_valid(ifu_resp_valid[1]),
    .ifu_resp_data(ifu_resp_data[1]), .ifu_resp_ready(ifu_resp_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_req_readop(lsu_req_readop), .lsu_req_ready(lsu_req_ready[1]),
    .lsu_resp_valid(lsu_resp_valid[1]), .lsu_resp_data(lsu_resp_data[1]),
    .lsu_resp_ready(lsu_resp_ready),
    .mem_valid(mem_valid[1]), .mem_wen(mem_wen[1]), .mem_raddr(mem_raddr[1]),
    .mem_waddr(mem_waddr[1]), .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]),
    .mem_readop(mem_readop[1]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready[2]), .ifu_resp_valid(ifu_resp_valid[2]),
    .ifu_resp_data(ifu_resp_data[2]), .ifu_resp_ready(ifu_resp_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_req_readop(lsu_req_readop), .lsu_req_ready(lsu_req_ready[2]),
    .lsu_resp_valid(lsu_resp_valid[2]), .lsu_resp_data(lsu_resp_data[2]),
    .lsu_resp_ready(lsu_resp_ready),
    .mem_valid(mem_valid[2]), .mem_wen(mem_wen[2]), .mem_raddr(mem_raddr[2]),
    .mem_waddr(mem_waddr[2]), .mem_wdata(mem_wdata[2]), .mem_wmask(mem_wmask[2]),
    .mem_readop(mem_readop[2]), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs of one instance packed together, for all-zero checks.
  function automatic logic [176:0] outs_of(input int i);
    return {ifu_req_ready[i], ifu_resp_valid[i], ifu_resp_data[i], lsu_req_ready[i],
            lsu_resp_valid[i], lsu_resp_data[i], mem_valid[i], mem_wen[i], mem_raddr[i],
            mem_waddr[i], mem_wdata[i], mem_wmask[i], mem_readop[i]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0;
    ifu_req_addr   = '0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_req_wen    = 1'b0;
    lsu_req_addr   = '0;
    lsu_req_wdata  = '0;
    lsu_req_wmask  = '0;
    lsu_req_readop = '0;
    lsu_resp_ready = 1'b0;
    mem_rdata      = '0;
  endtask

  // Leaves the bench in the first cycle with rst low, inputs idle.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    total++;
    if ({ifu_req_ready, lsu_req_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ready_in_rst: got %b want 000000", {ifu_req_ready, lsu_req_ready});
    end
    clear_inputs();
    cyc();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (outs_of(i) !== '0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, outs_of(i));
      end
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    total++;
    if (ifu_req_ready[0] !== 1'b1 || mem_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL fetch_accept: ready=%b strobe=%b want 1 0", ifu_req_ready[0], mem_valid[0]);
    end
    cyc();
    ifu_req_valid = 1'b0;
    ifu_req_addr  = 32'h0000_1234;
    mem_rdata     = 32'h0000_0413;
    #1;
    total++;
    if ({mem_valid[0], mem_wen[0], mem_readop[0], mem_raddr[0]} !== {2'b10, 3'd2, 32'h8000_0000})
    begin
      bad++;
      $display("FAIL fetch_strobe: valid=%b wen=%b op=%0d addr=%h want 1 0 2 80000000",
               mem_valid[0], mem_wen[0], mem_readop[0], mem_raddr[0]);
    end
    total++;
    if (ifu_resp_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL fetch_resp_early: got %b want 0", ifu_resp_valid[0]);
    end
    cyc();
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    total++;
    if ({ifu_resp_valid[0], lsu_resp_valid[0], mem_valid[0], ifu_resp_data[0]} !==
        {3'b100, 32'h0000_0413}) begin
      bad++;
      $display("FAIL fetch_resp: ifu_v=%b lsu_v=%b strobe=%b data=%h want 1 0 0 00000413",
               ifu_resp_valid[0], lsu_resp_valid[0], mem_valid[0], ifu_resp_data[0]);
    end
    ifu_resp_ready = 1'b1;
    cyc();
    ifu_resp_ready = 1'b0;
    #1;
    total++;
    if ({ifu_resp_valid[0], mem_valid[0]} !== 2'b00) begin
      bad++;
      $display("FAIL fetch_done: resp_v=%b strobe=%b want 0 0", ifu_resp_valid[0], mem_valid[0]);
    end
  endtask

  // Three back-to-back conflicts on the MEM_LAT=1 instance: LSU, IFU, LSU.
  task automatic test_conflict();
    logic [2:0]  exp_lsu;
    logic        lsu_wins;
    logic [31:0] exp_addr;
    logic [2:0]  exp_op;
    exp_lsu = 3'b101;
    do_reset();
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      lsu_wins       = exp_lsu[r];
      ifu_req_valid  = 1'b1;
      ifu_req_addr   = 32'h8000_0000 + 32'(r * 4);
      lsu_req_valid  = 1'b1;
      lsu_req_wen    = 1'b0;
      lsu_req_addr   = 32'h9000_0000 + 32'(r * 4);
      lsu_req_readop = OP_LBU;
      mem_rdata      = 32'h0000_00A0 + 32'(r);
      exp_addr       = lsu_wins ? lsu_req_addr : ifu_req_addr;
      exp_op         = lsu_wins ? OP_LBU : OP_LW;
      #1;
      total++;
      if ({ifu_req_ready[0], lsu_req_ready[0]} !== {!lsu_wins, lsu_wins}) begin
        bad++;
        $display("FAIL conflict_grant[%0d]: ifu_rdy=%b lsu_rdy=%b want %b %b", r,
                 ifu_req_ready[0], lsu_req_ready[0], !lsu_wins, lsu_wins);
      end
      cyc();
      #1;
      total++;
      if ({mem_valid[0], mem_raddr[0], mem_readop[0], ifu_req_ready[0], lsu_req_ready[0]} !==
          {1'b1, exp_addr, exp_op, 2'b00}) begin
        bad++;
        $display("FAIL conflict_access[%0d]: strobe=%b addr=%h op=%0d want 1 %h %0d", r,
                 mem_valid[0], mem_raddr[0], mem_readop[0], exp_addr, exp_op);
      end
      cyc();
      #1;
      total++;
      if ({lsu_resp_valid[0], ifu_resp_valid[0], ifu_req_ready[0], lsu_req_ready[0],
           lsu_resp_data[0]} !== {lsu_wins, !lsu_wins, 2'b00, 32'h0000_00A0 + 32'(r)}) begin
        bad++;
        $display("FAIL conflict_resp[%0d]: lsu_v=%b ifu_v=%b rdy=%b%b data=%h want %b %b 00 %h",
                 r, lsu_resp_valid[0], ifu_resp_valid[0], ifu_req_ready[0], lsu_req_ready[0],
                 lsu_resp_data[0], lsu_wins, !lsu_wins, 32'h0000_00A0 + 32'(r));
      end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_store();
    do_reset();
    lsu_req_valid  = 1'b1;
    lsu_req_wen    = 1'b1;
    lsu_req_addr   = 32'h8000_0100;
    lsu_req_wdata  = 32'hDEAD_BEEF;
    lsu_req_wmask  = 8'h0F;
    lsu_req_readop = OP_LW;
    mem_rdata      = 32'h1234_5678;
    #1;
    total++;
    if (lsu_req_ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL store_accept: got %b want 1", lsu_req_ready[1]);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      // Scramble the request fields: only the handshake values may be used.
      lsu_req_valid = 1'b0;
      lsu_req_addr  = '0;
      lsu_req_wdata = '0;
      lsu_req_wmask = '0;
      #1;
      total++;
      if ({mem_wen[1], mem_valid[1], lsu_resp_valid[1]} !== {k == 3, 1'b0, k == 4}) begin
        bad++;
        $display("FAIL store_timing[T+%0d]: wen=%b valid=%b resp_v=%b want %b 0 %b", k,
                 mem_wen[1], mem_valid[1], lsu_resp_valid[1], k == 3, k == 4);
      end
      if (k == 3) begin
        total++;
        if ({mem_waddr[1], mem_wdata[1], mem_wmask[1]} !== {32'h8000_0100, 32'hDEAD_BEEF, 8'h0F})
        begin
          bad++;
          $display("FAIL store_fields: addr=%h data=%h mask=%h want 80000100 deadbeef 0f",
                   mem_waddr[1], mem_wdata[1], mem_wmask[1]);
        end
      end
      if (k == 4) begin
        total++;
        if (lsu_resp_data[1] !== 32'h0) begin
          bad++;
          $display("FAIL store_resp_data: got %h want 00000000", lsu_resp_data[1]);
        end
      end
    end
    clear_inputs();
  endtask

  // Load with an unused readop, response stalled 5 cycles, then a withdrawn LSU request.
  task automatic test_backpressure();
    do_reset();
    lsu_req_valid  = 1'b1;
    lsu_req_wen    = 1'b0;
    lsu_req_addr   = 32'h8000_0200;
    lsu_req_readop = 3'd3;
    #1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      lsu_req_valid = 1'b0;
      mem_rdata     = (k == 3) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
    end
    #1;
    total++;
    if ({mem_valid[1], mem_readop[1], mem_raddr[1]} !== {1'b1, 3'd3, 32'h8000_0200}) begin
      bad++;
      $display("FAIL bp_access: strobe=%b op=%0d addr=%h want 1 3 80000200",
               mem_valid[1], mem_readop[1], mem_raddr[1]);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      mem_rdata     = 32'h1111_1111 * 32'(k + 1);
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 32'h8000_0300;
      lsu_req_valid = 1'b1;
      #1;
      total++;
      if ({lsu_resp_valid[1], ifu_resp_valid[1], ifu_req_ready[1], lsu_req_ready[1],
           mem_valid[1], mem_wen[1], lsu_resp_data[1]} !== {6'b100000, 32'hCAFE_F00D}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: lsu_v=%b ifu_v=%b rdy=%b%b strb=%b%b data=%h want 1 0 00 00 cafef00d",
                 k, lsu_resp_valid[1], ifu_resp_valid[1], ifu_req_ready[1], lsu_req_ready[1],
                 mem_valid[1], mem_wen[1], lsu_resp_data[1]);
      end
    end
    cyc();
    lsu_resp_ready = 1'b1;
    lsu_req_valid  = 1'b0;
    #1;
    total++;
    if ({lsu_resp_valid[1], ifu_req_ready[1]} !== 2'b10) begin
      bad++;
      $display("FAIL bp_no_accept_in_resp: resp_v=%b ifu_rdy=%b want 1 0",
               lsu_resp_valid[1], ifu_req_ready[1]);
    end
    cyc();
    lsu_resp_ready = 1'b0;
    #1;
    total++;
    if ({ifu_req_ready[1], lsu_req_ready[1], lsu_resp_valid[1]} !== 3'b100) begin
      bad++;
      $display("FAIL bp_idle_ready: ifu_rdy=%b lsu_rdy=%b resp_v=%b want 1 0 0",
               ifu_req_ready[1], lsu_req_ready[1], lsu_resp_valid[1]);
    end
    // Withdraw before the edge: nothing must be accepted.
    ifu_req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      #1;
      total++;
      if ({mem_valid[1], mem_wen[1], ifu_resp_valid[1], lsu_resp_valid[1]} !== 4'b0) begin
        bad++;
        $display("FAIL withdrawn[%0d]: strb=%b%b resp=%b%b want 0000", k, mem_valid[1],
                 mem_wen[1], ifu_resp_valid[1], lsu_resp_valid[1]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0080;
    mem_rdata     = 32'h7777_7777;
    #1;
    total++;
    if (ifu_req_ready[2] !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_accept: got %b want 1", ifu_req_ready[2]);
    end
    cyc();
    ifu_req_valid = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    total++;
    if ({mem_valid[2], mem_wen[2]} !== 2'b00) begin
      bad++;
      $display("FAIL rstwait_rst_cycle: strb=%b%b want 00", mem_valid[2], mem_wen[2]);
    end
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if (outs_of(2) !== '0) begin
      bad++;
      $display("FAIL rstwait_outputs: got %h want 0", outs_of(2));
    end
    for (int k = 4; k <= 9; k++) begin
      cyc();
      #1;
      total++;
      if ({mem_valid[2], mem_wen[2], ifu_resp_valid[2]} !== 3'b000) begin
        bad++;
        $display("FAIL rstwait_quiet[T+%0d]: strb=%b%b resp_v=%b want 000", k, mem_valid[2],
                 mem_wen[2], ifu_resp_valid[2]);
      end
    end
    cyc();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0040;
    mem_rdata     = 32'h0000_0055;
    #1;
    total++;
    if (ifu_req_ready[2] !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_fresh_accept: got %b want 1", ifu_req_ready[2]);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      ifu_req_valid = 1'b0;
      #1;
      total++;
      if ({mem_valid[2], ifu_resp_valid[2]} !== {k == 5, k == 6}) begin
        bad++;
        $display("FAIL rstwait_fresh[H+%0d]: strobe=%b resp_v=%b want %b %b", k, mem_valid[2],
                 ifu_resp_valid[2], k == 5, k == 6);
      end
      if (k == 5) begin
        total++;
        if (mem_raddr[2] !== 32'h8000_0040) begin
          bad++;
          $display("FAIL rstwait_fresh_addr: got %h want 80000040", mem_raddr[2]);
        end
      end
      if (k == 6) begin
        total++;
        if (ifu_resp_data[2] !== 32'h0000_0055) begin
          bad++;
          $display("FAIL rstwait_fresh_data: got %h want 00000055", ifu_resp_data[2]);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_conflict();
    test_store();
    test_backpressure();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
